// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes and FSM states.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,
    OP_MULH = 2'd1,
    OP_DIV  = 2'd2,
    OP_REM  = 2'd3
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } muldiv_state_t;

  // DIV and REM share the upper encoding bit.
  function automatic logic is_div_op(input muldiv_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Operand capture, shift-add / restoring shift-subtract accumulators and sign fix-up
// for iter_muldiv. Sequenced by single-cycle strobes from the controller.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             prep,
  input  logic             step,
  input  logic             fin,
  input  muldiv_op_t       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             div_zero,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  logic [WIDTH-1:0]   a_q, b_q, m_q, hi_q, lo_q;
  muldiv_op_t         op_q;
  logic               sgn_q, neg_q, aneg_q;

  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_rs, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res_next;

  assign sa       = sgn_q & a_q[WIDTH-1];
  assign sb       = sgn_q & b_q[WIDTH-1];
  assign mag_a    = sa ? -a_q : a_q;
  assign mag_b    = sb ? -b_q : b_q;
  assign div_zero = is_div_op(op_q) && (b_q == '0);

  // The divisor magnitude never exceeds 2^WIDTH-1, so WIDTH+1 bits hold the trial value.
  assign div_rs   = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_rs - {1'b0, m_q};

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    mul_sum = {1'b0, hi_q};
    if (lo_q[0]) mul_sum = {1'b0, hi_q} + {1'b0, m_q};
  end

  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = aneg_q ? -hi_q : hi_q;

  always_comb begin
    res_next = prod_fix[WIDTH-1:0];
    case (op_q)
      OP_MUL:  res_next = prod_fix[WIDTH-1:0];
      OP_MULH: res_next = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV:  res_next = div_zero ? '1 : quo_fix;
      OP_REM:  res_next = div_zero ? a_q : rem_fix;
      default: res_next = prod_fix[WIDTH-1:0];
    endcase
  end

  // NOTE: state registers use non-blocking assignments only; the accumulators are reset
  // too, so an aborted operation leaves no stale partial result behind.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      op_q        <= OP_MUL;
      sgn_q       <= 1'b0;
      neg_q       <= 1'b0;
      aneg_q      <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (load) begin
        a_q   <= a;
        b_q   <= b;
        op_q  <= op;
        sgn_q <= is_signed;
      end
      if (prep) begin
        hi_q   <= '0;
        neg_q  <= sa ^ sb;
        aneg_q <= sa;
        if (is_div_op(op_q)) begin
          m_q  <= mag_b;
          lo_q <= mag_a;
        end else begin
          m_q  <= mag_a;
          lo_q <= mag_b;
        end
      end
      if (step) begin
        if (is_div_op(op_q)) begin
          hi_q <= div_diff[WIDTH] ? div_rs[WIDTH-1:0] : div_diff[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          hi_q <= mul_sum[WIDTH:1];
          lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
        end
      end
      if (fin) begin
        result      <= res_next;
        div_by_zero <= div_zero;
      end
    end
  end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative WIDTH-bit multiply/divide unit: controller FSM and step counter.
// Optional MULDIV_DIVZERO_FAST_EN skips the iterations for DIV/REM by zero.
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

`ifdef MULDIV_DIVZERO_FAST_EN
  localparam bit FAST_DZ = 1'b1;
`else
  localparam bit FAST_DZ = 1'b0;
`endif

  muldiv_state_t state_q;
  logic [CW-1:0] cnt_q;
  logic          div_zero, skip_iter;
  logic          load, prep, step, fin;

  assign skip_iter = FAST_DZ && div_zero;
  assign load      = (state_q == ST_IDLE) && start;
  assign prep      = (state_q == ST_PREP);
  assign step      = (state_q == ST_ITER);
  assign fin       = (state_q == ST_FIX) || (prep && skip_iter);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_q <= ST_PREP;
            ready   <= 1'b0;
          end
        end
        ST_PREP: begin
          cnt_q <= CW'(WIDTH - 1);
          if (skip_iter) begin
            state_q <= ST_DONE;
            done    <= 1'b1;
          end else begin
            state_q <= ST_ITER;
          end
        end
        ST_ITER: begin
          if (cnt_q == '0) state_q <= ST_FIX;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_FIX: begin
          state_q <= ST_DONE;
          done    <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done    <= 1'b0;
          ready   <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          done    <= 1'b0;
          ready   <= 1'b1;
        end
      endcase
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .Clk         (Clk),
    .Reset       (Reset),
    .load        (load),
    .prep        (prep),
    .step        (step),
    .fin         (fin),
    .op          (muldiv_op_t'(op)),
    .is_signed   (is_signed),
    .a           (a),
    .b           (b),
    .div_zero    (div_zero),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

endmodule

// File: doc/iter_muldiv.md
ITER_MULDIV -- requirements
Module: iter_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width in bits (legal: 8..64, even).
REQ-002 The block SHALL have port Clk  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request; accepted only when ready=1.
REQ-005 The block SHALL have port op  input  2  operation: MUL=0 (low product), MULH=1 (high product), DIV=2 (quotient), REM=3 (remainder).
REQ-006 The block SHALL have port is_signed  input  1  two's-complement operands when 1, unsigned when 0.
REQ-007 The block SHALL have ports a, b  input  WIDTH each  multiplicand/dividend and multiplier/divisor.
REQ-008 The block SHALL have port ready  output  1  high only in IDLE.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 The block SHALL have port result  output  WIDTH  operation result.
REQ-011 The block SHALL have port div_by_zero  output  1  valid with done; high for DIV/REM with b=0.

Function
REQ-012 FSM states SHALL be IDLE, PREP, ITER, FIX, DONE; Reset SHALL force IDLE.
REQ-013 IDLE->PREP on start=1; a, b, op, is_signed SHALL be captured on that edge and ignored afterwards.
REQ-014 PREP SHALL form magnitudes (signed mode), record result sign, load iteration counter with WIDTH-1, then go to ITER.
REQ-015 ITER SHALL do one shift-add (MUL/MULH) or one restoring shift-subtract (DIV/REM) step per cycle, decrement counter, and go to FIX after the step with counter=0 (exactly WIDTH cycles).
REQ-016 FIX SHALL apply sign correction (product sign = sign(a)^sign(b); quotient sign likewise; remainder sign = sign(a)), select the result field, then go to DONE.
REQ-017 DONE SHALL assert done for exactly one cycle, then return to IDLE; total latency start-accept edge to done high = WIDTH+3 cycles.
REQ-018 result SHALL hold its value from DONE until the next DONE; start asserted while ready=0 SHALL be ignored, not queued.
REQ-019 Products SHALL use a 2*WIDTH accumulator; MUL returns bits [WIDTH-1:0], MULH bits [2*WIDTH-1:WIDTH]; MUL result SHALL be identical for signed and unsigned.
REQ-020 Divide by zero: quotient SHALL be all ones, remainder SHALL be a, div_by_zero=1.
REQ-021 Signed overflow (a=most-negative, b=-1): quotient SHALL be a, remainder 0, div_by_zero=0.
REQ-022 start in the same cycle as done SHALL be ignored (ready=0 in DONE); start in the first IDLE cycle after SHALL be accepted.

Reset
REQ-023 On Reset: state IDLE, ready=1, done=0, result=0, div_by_zero=0, counter and accumulators 0.
REQ-024 Reset mid-operation SHALL abort the operation with no done pulse; Reset SHALL override start in the same cycle.

Configuration
REQ-025 Macro MULDIV_DIVZERO_FAST_EN: when defined, DIV/REM with b=0 SHALL go PREP->DONE directly (done 2 cycles after accept); when undefined, full WIDTH+3 latency; result values per REQ-020 either way.

Structure
REQ-026 Package muldiv_pkg SHALL hold the op enum (muldiv_op_t), the state enum (muldiv_state_t), and op encodings.
REQ-027 One sub-module muldiv_datapath SHALL hold accumulators, shift/add/subtract and sign correction; iter_muldiv SHALL hold FSM and counter.

Verification (WIDTH=32)
REQ-028 MUL unsigned a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0x00000001, done 35 cycles after accept; MULH same -> 0xFFFFFFFE.
REQ-029 MULH signed a=0xFFFFFFFF(-1), b=0x00000002 -> 0xFFFFFFFF; DIV signed a=-7, b=2 -> 0xFFFFFFFD(-3); REM -> 0xFFFFFFFF(-1).
REQ-030 DIV unsigned a=100, b=0 -> 0xFFFFFFFF, div_by_zero=1; REM -> 100; latency 2 with MULDIV_DIVZERO_FAST_EN, 35 without.
REQ-031 DIV signed a=0x80000000, b=0xFFFFFFFF -> 0x80000000, div_by_zero=0; REM -> 0.
REQ-032 Reset pulsed at ITER cycle 10 -> no done, ready=1 next cycle, result=0; start held high through busy -> exactly one done per accepted start.
